// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg
// Shared definitions for the seven-segment scan driver: FSM state encodings,
// the all-segments-off pattern and the hex-to-segment lookup table.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = lit).
package seg_scan_driver_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index 15 (F) first, down to index 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// seg_hex_decode
// Combinational hex nibble to seven-segment pattern.
// Ports:
//   nibble  in  4  hex value 0-F
//   seg_n   out 7  {g,f,e,d,c,b,a}, active-low
module seg_hex_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    import seg_scan_driver_pkg::*;

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Multiplexed common-anode seven-segment driver. Runs on sys_clk and advances
// one digit slot per scan_tick enable, inserting a blanking gap before each
// digit is driven. Frame inputs are shadow-latched at frame start so a frame
// is always displayed coherently.
// Ports:
//   sys_clk     in   1         system clock
//   sys_rst_n   in   1         synchronous active-low reset
//   scan_tick   in   1         one-cycle slot advance enable
//   data        in   4*DIGITS  hex nibble per digit
//   dp_in       in   DIGITS    decimal point per digit, active-high
//   digit_en    in   DIGITS    per-digit enable
//   lz_blank    in   1         leading-zero blanking enable
//   an          out  DIGITS    anode selects, active-low
//   seg         out  7         segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1         decimal point, active-low
//   frame_done  out  1         one-cycle pulse at frame wrap
//
// state | meaning
// IDLE  | out of reset, all off, waiting for the first tick
// BLANK | all anodes off for BLANK_CYCLES cycles before the next digit
// DRIVE | current digit driven until the next tick
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int BCW          = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  scan_tick,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);
    import seg_scan_driver_pkg::*;

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);
    localparam logic [BCW-1:0] CNT_LAST = BCW'(BLANK_CYCLES - 1);

    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic [BCW-1:0]       cnt;
    logic [4*DIGITS-1:0]  sh_data;
    logic [DIGITS-1:0]    sh_dp;
    logic [DIGITS-1:0]    sh_en;
    logic                 sh_lz;

    logic [3:0]           cur_nib;
    logic [6:0]           cur_seg;
    logic [DIGITS-1:0]    lz_mask;
    logic [DIGITS-1:0]    an_next;

    // A digit is blank when it and every digit above it are zero; digit 0
    // always shows so a zero value still displays "0".
    function automatic logic [DIGITS-1:0] calc_lz_mask(
        input logic [4*DIGITS-1:0] d,
        input logic                lz
    );
        logic above_zero;
        above_zero   = 1'b1;
        calc_lz_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            above_zero      = above_zero & (d[4*i +: 4] == 4'h0);
            calc_lz_mask[i] = lz & above_zero;
        end
    endfunction

    assign cur_nib = sh_data[{idx, 2'b00} +: 4];
    assign lz_mask = calc_lz_mask(sh_data, sh_lz);

    seg_hex_decode u_hex_decode (
        .nibble (cur_nib),
        .seg_n  (cur_seg)
    );

    always_comb begin
        an_next      = '1;
        an_next[idx] = ~sh_en[idx];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            sh_lz      <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_tick) begin
                        sh_data <= data;
                        sh_dp   <= dp_in;
                        sh_en   <= digit_en;
                        sh_lz   <= lz_blank;
                        idx     <= '0;
                        cnt     <= '0;
                        state   <= BLANK;
                    end
                end
                BLANK: begin
                    an  <= '1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DRIVE;
                        an    <= an_next;
                        seg   <= lz_mask[idx] ? SEG_OFF : cur_seg;
                        dp    <= ~sh_dp[idx];
                    end
                end
                DRIVE: begin
                    if (scan_tick) begin
                        an    <= '1;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                        cnt   <= '0;
                        state <= BLANK;
                        if (idx == LAST_IDX) begin
                            idx        <= '0;
                            sh_data    <= data;
                            sh_dp      <= dp_in;
                            sh_en      <= digit_en;
                            sh_lz      <= lz_blank;
                            frame_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Multiplexed common-anode seven-segment display driver with DIGITS digits.
- Sits directly downstream of the system clock divider. It consumes the divider's scan-rate output as a one-cycle enable, scan_tick, and stays on sys_clk; it never clocks on a divided clock.
- Each tick advances one digit slot.
- A programmable blanking gap between digits suppresses ghosting.
- Frame data is shadow-latched so a displayed frame is always coherent.

Parameters:
- DIGITS, 8: number of digits; must be ≥2.
- BLANK_CYCLES, 4: sys_clk cycles with all anodes off between digits; must be ≥1.
- BCW, 3: width of the blanking counter; must satisfy 2^BCW ≥ BLANK_CYCLES.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  synchronous, active-low reset, sampled on the sys_clk rising edge.
- scan_tick  in  1  one-cycle enable from the divider stage; 1 tick = 1 digit slot.
- data  in  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
- dp_in  in  DIGITS  decimal point per digit, active-high.
- digit_en  in  DIGITS  per-digit enable; a disabled digit keeps its slot but its anode stays off.
- lz_blank  in  1  1 = leading-zero blanking on.
- an  out  DIGITS  anode selects, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at frame wrap.

Behaviour:
- All outputs are registered.
- Reset values: an all 1, seg 7'h7F, dp 1, frame_done 0. State IDLE, idx 0, blanking counter 0, shadow registers 0.
- Reset asserted mid-operation: the next edge returns the block to the reset values; no partial digit is left driven.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - outputs stay at reset values;
  - on scan_tick: shadow ← {data, dp_in, digit_en, lz_blank}, idx ← 0, cnt ← 0, go to BLANK.
- BLANK:
  - an all 1; cnt increments each cycle;
  - when cnt == BLANK_CYCLES-1, next edge: go to DRIVE, an[idx] ← ~shadow_en[idx], seg ← decode or blank, dp ← ~shadow_dp[idx];
  - scan_tick during BLANK is ignored, not queued;
  - anode-low latency is exactly BLANK_CYCLES edges after the edge that entered BLANK.
- DRIVE:
  - holds outputs until scan_tick;
  - on scan_tick, at the same edge: an ← all 1, seg ← 7'h7F, dp ← 1, cnt ← 0, go to BLANK;
  - if idx == DIGITS-1: idx ← 0, shadow reloaded from inputs, frame_done ← 1 for that single cycle;
  - otherwise idx ← idx+1.
- Frame coherence: changes on data, dp_in, digit_en or lz_blank take effect only at the next frame wrap, or at the IDLE exit.
- Hex decode: 0-F to standard patterns (A-F as A,b,C,d,E,F). Segment bit = 0 means lit.
- Leading-zero blanking (shadow lz_blank = 1):
  - digit i (i ≥ 1) is blanked, seg = 7'h7F, when its nibble and all nibbles above i are 0;
  - digit 0 is never blanked;
  - dp is still driven for a blanked digit;
  - disabled digits count as their nibble value for this rule.
- digit_en all 0: the state machine still runs and frame_done still pulses; an stays all 1.
- Index width = $clog2(DIGITS). Wrap is explicit at DIGITS-1, so non-power-of-2 DIGITS is supported.

Decomposition:
- Shared package:
  - state enum {IDLE, BLANK, DRIVE};
  - SEG_OFF = 7'h7F;
  - 16-entry hex-to-segment constant table.
- One sub-module: seg_hex_decode, combinational, nibble → 7-bit active-low pattern.
- The leading-zero mask is a combinational function over the shadow data inside seg_scan_driver.

Test Plan:
- Reset, then hold sys_rst_n = 0 for 3 cycles with scan_tick pulsing -> an = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0 throughout.
- data = 32'h7654_3210, all enabled, lz_blank = 0, ticks every 20 cycles:
  - an walks FE, FD, FB … 7F with seg for 0..7 (digit 0 → 7'h40, digit 7 → 7'h78);
  - each anode goes low exactly 4 cycles after the tick;
  - frame_done pulses once per 8 ticks.
- data = 32'h0000_0105, lz_blank = 1 -> digits 7..3 seg = 7'h7F; digit 2 → 7'h79; digit 1 → 7'h40 (inner zero shown); digit 0 → 7'h12. data = 0 -> only digit 0 shows 7'h40.
- Change data mid-frame at digit 3 -> digits 4..7 still show old nibbles; new values appear only after the frame_done edge.
- digit_en = 8'b1010_1010 -> the an low pulse appears only in odd slots; slot timing is unchanged. digit_en = 0 -> an = FF while frame_done keeps pulsing every 8 ticks.
- Tick during BLANK (2 cycles after the previous tick) -> ignored, idx not advanced. Reset asserted while in DRIVE on digit 5 -> next edge an = FF, and the first post-reset tick restarts at digit 0.
